// File: rtl/cim_seq_pkg.sv
// Shared encodings for the CIM GeMM sequencer: command opcodes, FSM states,
// and the macro strobe bundle with its idle value.
package cim_seq_pkg;

  localparam int unsigned OP_W           = 2;
  localparam int unsigned STATE_W        = 3;
  localparam int unsigned OUT_SEL_W      = 4;
  localparam int unsigned BYTES_PER_WORD = 4;

  typedef enum logic [OP_W-1:0] {
    OP_LOAD_W  = 2'd0,
    OP_COMPUTE = 2'd1,
    OP_DRAIN   = 2'd2,
    OP_CLEAR   = 2'd3
  } op_e;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_COMPUTE   = 3'd2,
    ST_DRAIN_SEL = 3'd3,
    ST_DRAIN_OUT = 3'd4,
    ST_CLEAR     = 3'd5
  } state_e;

  // Per-cycle macro control strobes
  typedef struct packed {
    logic cs;
    logic web;
    logic cimeb;
    logic psum_eb;
    logic reset_out;
  } strobe_t;

  // Strobe values when the macro is not being accessed (cimeb is active-low)
  localparam strobe_t STROBE_IDLE = '{cs: 1'b0, web: 1'b0, cimeb: 1'b1,
                                      psum_eb: 1'b0, reset_out: 1'b0};

endpackage

// File: rtl/cim_load_addr_gen.sv
// Word counter for LOAD/COMPUTE plus weight-row address computation.
//   clk, rst   : clock, async active-high reset
//   clear      : restart the count at 0 (command accepted)
//   step       : one word consumed this cycle
//   base       : latched command base byte address
//   count      : index of the next word to be consumed (registered)
//   addr_c     : macro byte address for word 'count' (combinational)
module cim_load_addr_gen
  import cim_seq_pkg::*;
#(
  parameter int unsigned ADDR_W        = 32,
  parameter int unsigned LEN_W         = 8,
  parameter int unsigned WORDS_PER_ROW = 2,
  parameter int unsigned ROW_STRIDE    = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              step,
  input  logic [ADDR_W-1:0] base,
  output logic [LEN_W-1:0]  count,
  output logic [ADDR_W-1:0] addr_c
);

  localparam int unsigned COL_W = (WORDS_PER_ROW > 1) ? $clog2(WORDS_PER_ROW) : 0;

  logic [LEN_W-1:0] row_c;
  logic [LEN_W-1:0] col_c;

  // Word index counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (step) begin
      count <= count + LEN_W'(1);
    end
  end

  // WORDS_PER_ROW is a power of two, so row/column are a shift and a mask
  always_comb begin
    row_c  = count >> COL_W;
    col_c  = count & LEN_W'(WORDS_PER_ROW - 1);
    addr_c = base
           + ADDR_W'(row_c) * ADDR_W'(ROW_STRIDE)
           + ADDR_W'(col_c) * ADDR_W'(BYTES_PER_WORD);
  end

endmodule

// File: rtl/cim_gemm_sequencer.sv
// Command sequencer for the Basic_GeMM_CIM macro. Turns LOAD_W / COMPUTE /
// DRAIN / CLEAR commands into per-cycle macro strobes, address and data.
//   clk, rst                       : clock, async active-high reset
//   cmd_valid/ready, cmd_op/addr/len : command handshake and fields
//   in_valid/ready, in_data        : weight / input word stream
//   out_valid/ready, out_data, out_last : drained result stream
//   busy                           : high whenever not idle
//   cim_*                          : macro control, address, data; cim_rdata is the macro output
// All outputs are registered; a word accepted at edge N drives its macro
// access during the cycle following edge N.
module cim_gemm_sequencer
  import cim_seq_pkg::*;
#(
  parameter int unsigned ADDR_W        = 32,
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned NUM_OUT       = 8,
  parameter int unsigned WORDS_PER_ROW = 2,
  parameter int unsigned ROW_STRIDE    = 128,
  parameter int unsigned LEN_W         = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [OP_W-1:0]      cmd_op,
  input  logic [ADDR_W-1:0]    cmd_addr,
  input  logic [LEN_W-1:0]     cmd_len,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_W-1:0]    in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_W-1:0]    out_data,
  output logic                 out_last,
  output logic                 busy,
  output logic                 cim_cs,
  output logic                 cim_web,
  output logic                 cim_cimeb,
  output logic                 cim_psum_eb,
  output logic                 cim_reset_out,
  output logic [OUT_SEL_W-1:0] cim_out_sel,
  output logic [ADDR_W-1:0]    cim_addr,
  output logic [DATA_W-1:0]    cim_wdata,
  input  logic [DATA_W-1:0]    cim_rdata
);

  localparam logic [OUT_SEL_W-1:0] K_LAST = OUT_SEL_W'(NUM_OUT - 1);

  state_e                state_q, state_d;
  logic [ADDR_W-1:0]     base_q, base_d;
  logic [LEN_W-1:0]      len_q, len_d;
  logic [OUT_SEL_W-1:0]  k_q, k_d;
  strobe_t               strobe_q, strobe_d;

  logic                  cmd_ready_d, in_ready_d, out_valid_d, out_last_d, busy_d;
  logic [OUT_SEL_W-1:0]  out_sel_d;
  logic [ADDR_W-1:0]     addr_d;
  logic [DATA_W-1:0]     wdata_d, out_data_d;

  logic                  accept_cmd_c, word_c, last_word_c;
  logic [LEN_W-1:0]      count;
  logic [ADDR_W-1:0]     load_addr_c;

  assign accept_cmd_c = cmd_valid && cmd_ready;
  assign word_c       = in_valid && in_ready;
  assign last_word_c  = word_c && (count == len_q - LEN_W'(1));

  cim_load_addr_gen #(
    .ADDR_W       (ADDR_W),
    .LEN_W        (LEN_W),
    .WORDS_PER_ROW(WORDS_PER_ROW),
    .ROW_STRIDE   (ROW_STRIDE)
  ) u_addr_gen (
    .clk   (clk),
    .rst   (rst),
    .clear (accept_cmd_c),
    .step  (word_c),
    .base  (base_q),
    .count (count),
    .addr_c(load_addr_c)
  );

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      base_q      <= '0;
      len_q       <= '0;
      k_q         <= '0;
      strobe_q    <= STROBE_IDLE;
      cmd_ready   <= 1'b1;
      in_ready    <= 1'b0;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      busy        <= 1'b0;
      cim_out_sel <= '0;
      cim_addr    <= '0;
      cim_wdata   <= '0;
      out_data    <= '0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      len_q       <= len_d;
      k_q         <= k_d;
      strobe_q    <= strobe_d;
      cmd_ready   <= cmd_ready_d;
      in_ready    <= in_ready_d;
      out_valid   <= out_valid_d;
      out_last    <= out_last_d;
      busy        <= busy_d;
      cim_out_sel <= out_sel_d;
      cim_addr    <= addr_d;
      cim_wdata   <= wdata_d;
      out_data    <= out_data_d;
    end
  end

  assign cim_cs        = strobe_q.cs;
  assign cim_web       = strobe_q.web;
  assign cim_cimeb     = strobe_q.cimeb;
  assign cim_psum_eb   = strobe_q.psum_eb;
  assign cim_reset_out = strobe_q.reset_out;

  // Next state and next output values
  always_comb begin
    state_d    = state_q;
    base_d     = base_q;
    len_d      = len_q;
    k_d        = k_q;
    strobe_d   = STROBE_IDLE;
    out_sel_d  = '0;
    addr_d     = '0;
    wdata_d    = '0;
    out_data_d = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (accept_cmd_c) begin
          base_d = cmd_addr;
          len_d  = cmd_len;
          k_d    = '0;
          unique case (op_e'(cmd_op))
            OP_LOAD_W:  state_d = ST_LOAD;
            OP_COMPUTE: state_d = ST_COMPUTE;
            OP_DRAIN:   state_d = ST_DRAIN_SEL;
            OP_CLEAR:   state_d = ST_CLEAR;
          endcase
        end
      end
      ST_LOAD: begin
        if (word_c) begin
          strobe_d.cs  = 1'b1;
          strobe_d.web = 1'b1;
          addr_d       = load_addr_c;
          wdata_d      = in_data;
        end
        if (len_q == '0 || last_word_c) state_d = ST_IDLE;
      end
      ST_COMPUTE: begin
        if (word_c) begin
          strobe_d.cs      = 1'b1;
          strobe_d.cimeb   = 1'b0;
          strobe_d.psum_eb = 1'b1;
          addr_d           = base_q;
          wdata_d          = in_data;
        end
        if (len_q == '0 || last_word_c) state_d = ST_IDLE;
      end
      ST_DRAIN_SEL: begin
        // out_sel has been stable for one full cycle: sample the macro now
        state_d    = ST_DRAIN_OUT;
        out_data_d = cim_rdata;
      end
      ST_DRAIN_OUT: begin
        out_data_d = out_data;
        if (out_ready) begin
          if (k_q == K_LAST) begin
            state_d = ST_IDLE;
          end else begin
            k_d     = k_q + OUT_SEL_W'(1);
            state_d = ST_DRAIN_SEL;
          end
        end
      end
      ST_CLEAR: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs that depend only on the state being entered
    if (state_d == ST_DRAIN_SEL) begin
      strobe_d.cs    = 1'b1;
      strobe_d.cimeb = 1'b0;
      out_sel_d      = k_d;
    end
    if (state_d == ST_CLEAR) begin
      strobe_d.cs        = 1'b1;
      strobe_d.reset_out = 1'b1;
    end
    if (state_d != ST_DRAIN_OUT) out_data_d = '0;

    cmd_ready_d = (state_d == ST_IDLE);
    busy_d      = (state_d != ST_IDLE);
    // len=0 commands spend their one busy cycle without offering in_ready
    in_ready_d  = (state_d == ST_LOAD || state_d == ST_COMPUTE) &&
                  !(state_q == ST_IDLE && cmd_len == '0);
    out_valid_d = (state_d == ST_DRAIN_OUT);
    out_last_d  = (state_d == ST_DRAIN_OUT) && (k_d == K_LAST);
  end

endmodule

// File: tb/tb_cim_gemm_sequencer.sv
// Directed self-checking bench for cim_gemm_sequencer. The macro output is
// modelled as 0x100 + cim_out_sel.
module tb_cim_gemm_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic        busy;
  logic        cim_cs, cim_web, cim_cimeb, cim_psum_eb, cim_reset_out;
  logic [3:0]  cim_out_sel;
  logic [31:0] cim_addr;
  logic [31:0] cim_wdata;
  logic [31:0] cim_rdata;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  assign cim_rdata = 32'h0000_0100 + {28'd0, cim_out_sel};

  cim_gemm_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_addr     (cmd_addr),
    .cmd_len      (cmd_len),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_last     (out_last),
    .busy         (busy),
    .cim_cs       (cim_cs),
    .cim_web      (cim_web),
    .cim_cimeb    (cim_cimeb),
    .cim_psum_eb  (cim_psum_eb),
    .cim_reset_out(cim_reset_out),
    .cim_out_sel  (cim_out_sel),
    .cim_addr     (cim_addr),
    .cim_wdata    (cim_wdata),
    .cim_rdata    (cim_rdata)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one command and hold it until the accepting edge (bounded)
  task automatic send_cmd(input logic [1:0] op, input logic [31:0] addr, input logic [7:0] len);
    int n = 0;
    while (!cmd_ready && n < 50) begin
      step();
      n++;
    end
    tests++;
    if (!cmd_ready) begin
      fails++;
      $display("FAIL send_cmd: cmd_ready=%0b after %0d cycles, required 1", cmd_ready, n);
    end
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = addr;
    cmd_len   = len;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    tests++;
    if ({cmd_ready, in_ready, out_valid, out_last, busy} !== 5'b10000) begin
      fails++;
      $display("FAIL reset_handshake: {cmd_ready,in_ready,out_valid,out_last,busy}=%b required 10000",
               {cmd_ready, in_ready, out_valid, out_last, busy});
    end
    tests++;
    if ({cim_cs, cim_web, cim_cimeb, cim_psum_eb, cim_reset_out, cim_out_sel} !== 9'b00100_0000) begin
      fails++;
      $display("FAIL reset_strobes: got %b required 001000000",
               {cim_cs, cim_web, cim_cimeb, cim_psum_eb, cim_reset_out, cim_out_sel});
    end
    tests++;
    if ({cim_addr, cim_wdata, out_data} !== 96'd0) begin
      fails++;
      $display("FAIL reset_buses: addr=%h wdata=%h out_data=%h required 0", cim_addr, cim_wdata, out_data);
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_load();
    logic [31:0] exp_addr [8] = '{32'd0, 32'd4, 32'd128, 32'd132, 32'd256, 32'd260, 32'd384, 32'd388};
    logic [31:0] word;
    send_cmd(2'd0, 32'd0, 8'd8);
    tests++;
    if ({busy, in_ready, cmd_ready, cim_cs} !== 4'b1100) begin
      fails++;
      $display("FAIL load_start: {busy,in_ready,cmd_ready,cs}=%b required 1100", {busy, in_ready, cmd_ready, cim_cs});
    end
    for (int i = 0; i < 8; i++) begin
      word     = 32'h0302_0100 + 32'h0404_0404 * i;
      in_valid = 1'b1;
      in_data  = word;
      step();
      tests++;
      if ({cim_cs, cim_web, cim_cimeb, cim_psum_eb} !== 4'b1110 || cim_addr !== exp_addr[i] ||
          cim_wdata !== word) begin
        fails++;
        $display("FAIL load_word%0d: cs/web/cimeb/psum=%b addr=%h wdata=%h required 1110 addr=%h wdata=%h",
                 i, {cim_cs, cim_web, cim_cimeb, cim_psum_eb}, cim_addr, cim_wdata, exp_addr[i], word);
      end
    end
    in_valid = 1'b0;
    tests++;
    if ({busy, cmd_ready, in_ready} !== 3'b010) begin
      fails++;
      $display("FAIL load_end: {busy,cmd_ready,in_ready}=%b required 010", {busy, cmd_ready, in_ready});
    end
    step();
    tests++;
    if ({cim_cs, cim_cimeb} !== 2'b01) begin
      fails++;
      $display("FAIL load_after: {cs,cimeb}=%b required 01", {cim_cs, cim_cimeb});
    end
  endtask

  task automatic test_compute();
    logic [31:0] words [2] = '{32'h3333_3333, 32'h4444_4444};
    send_cmd(2'd1, 32'd0, 8'd2);
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_data  = words[i];
      step();
      tests++;
      if ({cim_cs, cim_web, cim_cimeb, cim_psum_eb} !== 4'b1001 || cim_addr !== 32'd0 ||
          cim_wdata !== words[i]) begin
        fails++;
        $display("FAIL compute_word%0d: cs/web/cimeb/psum=%b addr=%h wdata=%h required 1001 addr=0 wdata=%h",
                 i, {cim_cs, cim_web, cim_cimeb, cim_psum_eb}, cim_addr, cim_wdata, words[i]);
      end
    end
    in_valid = 1'b0;
    tests++;
    if ({busy, cmd_ready} !== 2'b01) begin
      fails++;
      $display("FAIL compute_end: {busy,cmd_ready}=%b required 01", {busy, cmd_ready});
    end
    step();
  endtask

  task automatic test_drain();
    int n;
    logic [31:0] held;
    out_ready = 1'b0;
    send_cmd(2'd2, 32'd0, 8'd0);
    tests++;
    if ({cim_cs, cim_cimeb, cim_psum_eb, cim_out_sel, out_valid} !== 8'b1000_0000) begin
      fails++;
      $display("FAIL drain_sel0: {cs,cimeb,psum,out_sel,out_valid}=%b required 10000000",
               {cim_cs, cim_cimeb, cim_psum_eb, cim_out_sel, out_valid});
    end
    for (int k = 0; k < 8; k++) begin
      n = 0;
      while (!out_valid && n < 4) begin
        step();
        n++;
      end
      tests++;
      if (!out_valid || out_data !== 32'h100 + k || out_last !== (k == 7)) begin
        fails++;
        $display("FAIL drain_word%0d: valid=%0b data=%h last=%0b required valid=1 data=%h last=%0b",
                 k, out_valid, out_data, out_last, 32'h100 + k, (k == 7));
      end
      if (k == 3) begin
        held = out_data;
        repeat (3) step();
        tests++;
        if (!out_valid || out_data !== held || out_last !== 1'b0) begin
          fails++;
          $display("FAIL drain_hold: valid=%0b data=%h last=%0b required valid=1 data=%h last=0",
                   out_valid, out_data, out_last, held);
        end
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      if (k < 7) begin
        tests++;
        if (cim_out_sel !== 4'(k + 1) || cim_cs !== 1'b1 || out_valid !== 1'b0) begin
          fails++;
          $display("FAIL drain_sel%0d: out_sel=%0d cs=%0b valid=%0b required out_sel=%0d cs=1 valid=0",
                   k + 1, cim_out_sel, cim_cs, out_valid, k + 1);
        end
      end
    end
    tests++;
    if ({busy, cmd_ready, out_valid, out_last, cim_cs} !== 5'b01000 || out_data !== 32'd0) begin
      fails++;
      $display("FAIL drain_end: {busy,cmd_ready,valid,last,cs}=%b data=%h required 01000 data=0",
               {busy, cmd_ready, out_valid, out_last, cim_cs}, out_data);
    end
  endtask

  task automatic test_gaps();
    logic pat    [9] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic exp_cs [9] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    int accesses = 0;
    send_cmd(2'd1, 32'h10, 8'd4);
    for (int c = 0; c < 9; c++) begin
      in_valid = pat[c];
      in_data  = 32'hA0 + c;
      step();
      if (cim_cs) accesses++;
      tests++;
      if ({cim_cs, cim_cimeb, cim_psum_eb} !== {exp_cs[c], !exp_cs[c], exp_cs[c]} ||
          (exp_cs[c] && (cim_addr !== 32'h10 || cim_wdata !== 32'hA0 + c))) begin
        fails++;
        $display("FAIL gap_cycle%0d: {cs,cimeb,psum}=%b addr=%h wdata=%h required cs=%0b addr=10 wdata=%h",
                 c, {cim_cs, cim_cimeb, cim_psum_eb}, cim_addr, cim_wdata, exp_cs[c], 32'hA0 + c);
      end
    end
    in_valid = 1'b0;
    tests++;
    if (accesses !== 4 || busy !== 1'b0) begin
      fails++;
      $display("FAIL gap_count: accesses=%0d busy=%0b required 4 and 0", accesses, busy);
    end
  endtask

  task automatic test_clear_len0();
    send_cmd(2'd3, 32'd0, 8'd0);
    tests++;
    if ({cim_cs, cim_reset_out, busy, cmd_ready} !== 4'b1110) begin
      fails++;
      $display("FAIL clear_pulse: {cs,reset_out,busy,cmd_ready}=%b required 1110",
               {cim_cs, cim_reset_out, busy, cmd_ready});
    end
    step();
    tests++;
    if ({cim_cs, cim_reset_out, busy, cmd_ready} !== 4'b0001) begin
      fails++;
      $display("FAIL clear_end: {cs,reset_out,busy,cmd_ready}=%b required 0001",
               {cim_cs, cim_reset_out, busy, cmd_ready});
    end
    in_valid = 1'b1;
    in_data  = 32'hDEAD_BEEF;
    send_cmd(2'd0, 32'h40, 8'd0);
    tests++;
    if ({busy, in_ready, cim_cs, cmd_ready} !== 4'b1000) begin
      fails++;
      $display("FAIL len0_busy: {busy,in_ready,cs,cmd_ready}=%b required 1000",
               {busy, in_ready, cim_cs, cmd_ready});
    end
    step();
    tests++;
    if ({busy, in_ready, cim_cs, cmd_ready} !== 4'b0001) begin
      fails++;
      $display("FAIL len0_end: {busy,in_ready,cs,cmd_ready}=%b required 0001",
               {busy, in_ready, cim_cs, cmd_ready});
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_drain();
    int n = 0;
    out_ready = 1'b1;
    send_cmd(2'd2, 32'd0, 8'd0);
    while (!(out_valid && out_data == 32'h103) && n < 20) begin
      step();
      n++;
    end
    tests++;
    if (!(out_valid && out_data == 32'h103)) begin
      fails++;
      $display("FAIL rst_reach_k3: valid=%0b data=%h required valid=1 data=103", out_valid, out_data);
    end
    rst = 1'b1;
    #1;
    tests++;
    if ({cmd_ready, in_ready, out_valid, out_last, busy, cim_cs, cim_cimeb, cim_out_sel} !== 11'b10000_01_0000 ||
        out_data !== 32'd0) begin
      fails++;
      $display("FAIL rst_async: ctl=%b out_data=%h required 10000010000 and 0",
               {cmd_ready, in_ready, out_valid, out_last, busy, cim_cs, cim_cimeb, cim_out_sel}, out_data);
    end
    #2;
    rst = 1'b0;
    out_ready = 1'b0;
    step();
    send_cmd(2'd2, 32'd0, 8'd0);
    tests++;
    if (cim_out_sel !== 4'd0 || cim_cs !== 1'b1) begin
      fails++;
      $display("FAIL rst_restart_sel: out_sel=%0d cs=%0b required 0 and 1", cim_out_sel, cim_cs);
    end
    step();
    tests++;
    if (out_valid !== 1'b1 || out_data !== 32'h100) begin
      fails++;
      $display("FAIL rst_restart_data: valid=%0b data=%h required 1 and 100", out_valid, out_data);
    end
    rst = 1'b1;
    #2;
    rst = 1'b0;
    step();
  endtask

  initial begin
    cmd_valid = 1'b0;
    cmd_op    = 2'd0;
    cmd_addr  = 32'd0;
    cmd_len   = 8'd0;
    in_valid  = 1'b0;
    in_data   = 32'd0;
    out_ready = 1'b0;
    test_reset();
    test_load();
    test_compute();
    test_drain();
    test_gaps();
    test_clear_len0();
    test_reset_mid_drain();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

endmodule
